// File: rtl/mips_multicycle_control_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control_if
// Control bundle between the multicycle MIPS control FSM and its datapath.
//   slave  : the control FSM (consumes opcode/mem_ready, drives enables)
//   master : the datapath / testbench side
// Signals:
//   opcode        IR[31:26], stable from DECODE until the next FETCH
//   mem_ready     memory completed the current read or write this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
//                 datapath control enables and mux selects
//   state         current FSM state, for debug
//   err_illegal_opcode  one-cycle pulse on an unsupported opcode
//   retired_count completed-instruction counter, COUNT_W bits, wraps
// ----------------------------------------------------------------------------
interface mips_multicycle_control_if #(
  parameter int COUNT_W = 16
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic [3:0]         state;
  logic               err_illegal_opcode;
  logic [COUNT_W-1:0] retired_count;

  modport slave (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, err_illegal_opcode, retired_count
  );

  modport master (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, err_illegal_opcode, retired_count
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// mips_multicycle_control
// Main control FSM of the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback for R-type, lw, sw, beq, j and addi, stalls
// memory states on mem_ready, traps illegal opcodes and counts retirements.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high
//   bus    control bundle (slave side), see mips_multicycle_control_if
// All bus outputs except retired_count are decoded combinationally from the
// state register; mem_ready gates ir_write/pc_write in FETCH.
// ----------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t             r_state;
  state_t             w_next;
  logic               w_retire;
  logic [COUNT_W-1:0] r_retired;

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_R:         w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          default:      w_next = S_TRAP;
        endcase
      end
      // Only lw/sw reach here; anything other than lw is treated as sw.
      S_MEM_ADDR:  w_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC:      w_next = S_ALU_WB;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  // An instruction retires when a completing state hands back to FETCH;
  // the FETCH check matters for MEM_WRITE, which may stall in place.
  always_comb begin
    w_retire = 1'b0;
    if (w_next == S_FETCH) begin
      case (r_state)
        S_MEM_WB, S_MEM_WRITE, S_ALU_WB,
        S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
        default:                     w_retire = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and only the state and counter need it; outputs follow state.
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Output decode from state; unlisted outputs stay 0.
  always_comb begin
    bus.pc_write           = 1'b0;
    bus.pc_write_cond      = 1'b0;
    bus.i_or_d             = 1'b0;
    bus.mem_read           = 1'b0;
    bus.mem_write          = 1'b0;
    bus.ir_write           = 1'b0;
    bus.mem_to_reg         = 1'b0;
    bus.reg_dst            = 1'b0;
    bus.reg_write          = 1'b0;
    bus.alu_src_a          = 1'b0;
    bus.alu_src_b          = 2'b00;
    bus.alu_op             = 2'b00;
    bus.pc_source          = 2'b00;
    bus.err_illegal_opcode = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC only load once the instruction word is actually back.
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE:    bus.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDI_WB:   bus.reg_write = 1'b1;
      S_TRAP:      bus.err_illegal_opcode = 1'b1;
      default: ;
    endcase
  end

  assign bus.state         = r_state;
  assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_control
// Directed bench for mips_multicycle_control. A 16-bit counter instance covers
// the instruction flows; a COUNT_W=4 instance covers counter wrap.
// Control word layout used by the expected-value tables (17 bits, MSB first):
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0], err_illegal_opcode
// ----------------------------------------------------------------------------
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.COUNT_W(16)) u_if  ();
  mips_multicycle_control_if #(.COUNT_W(4))  u_if4 ();

  mips_multicycle_control #(.COUNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  mips_multicycle_control #(.COUNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if4)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  //                                   pw   pwc  iord mr   mw   irw  m2r  rdst rw   asa  asb    aop    psrc   err
  localparam logic [16:0] C_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_FSTALL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MREAD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MWRITE = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] C_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] C_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] C_AEXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_TRAP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] exp_retired = '0;
  bit saw_alu_op_11 = 1'b0;

  // Sticky monitor: alu_op must never be 11 on either instance.
  always @(negedge clk) begin
    if (u_if.alu_op === 2'b11 || u_if4.alu_op === 2'b11) saw_alu_op_11 = 1'b1;
  end

  function automatic logic [20:0] observed();
    return {u_if.state, u_if.pc_write, u_if.pc_write_cond, u_if.i_or_d, u_if.mem_read,
            u_if.mem_write, u_if.ir_write, u_if.mem_to_reg, u_if.reg_dst, u_if.reg_write,
            u_if.alu_src_a, u_if.alu_src_b, u_if.alu_op, u_if.pc_source,
            u_if.err_illegal_opcode};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    reset = 1'b1;
    u_if.opcode = OP_R;  u_if.mem_ready = 1'b0;
    u_if4.opcode = OP_J; u_if4.mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    obs = observed();
    tests_run++;
    if (obs !== {4'd0, C_FSTALL} || u_if.retired_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset: state/ctrl=%h count=%0d, want %h count=0",
               obs, u_if.retired_count, {4'd0, C_FSTALL});
    end
    exp_retired = '0;
  endtask

  task automatic test_rtype();
    logic [20:0] exp [5];
    logic [20:0] obs;
    exp = '{{4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd6, C_EXEC}, {4'd7, C_ALUWB}, {4'd0, C_FETCH}};
    u_if.opcode = OP_R;
    u_if.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      obs = observed();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL rtype cycle %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 4) tick();
    end
    exp_retired++;
    tests_run++;
    if (u_if.retired_count !== exp_retired) begin
      tests_failed++;
      $display("FAIL rtype retire: got %0d want %0d", u_if.retired_count, exp_retired);
    end
  endtask

  task automatic test_lw_stall();
    logic [20:0] exp [9];
    logic        rdy [9];
    logic [20:0] obs;
    exp = '{{4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd2, C_MADDR},
            {4'd3, C_MREAD}, {4'd3, C_MREAD}, {4'd3, C_MREAD}, {4'd3, C_MREAD},
            {4'd4, C_MWB}, {4'd0, C_FETCH}};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    u_if.opcode = OP_LW;
    for (int i = 0; i < 9; i++) begin
      u_if.mem_ready = rdy[i];
      #1;
      obs = observed();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL lw_stall cycle %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 8) tick();
    end
    exp_retired++;
    tests_run++;
    if (u_if.retired_count !== exp_retired) begin
      tests_failed++;
      $display("FAIL lw_stall retire: got %0d want %0d", u_if.retired_count, exp_retired);
    end
  endtask

  // beq then j back to back, plus a stalled FETCH in between.
  task automatic test_branch_jump();
    logic [20:0] exp [8];
    logic [5:0]  op  [8];
    logic        rdy [8];
    logic [20:0] obs;
    exp = '{{4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd8, C_BRANCH},
            {4'd0, C_FSTALL}, {4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd9, C_JUMP},
            {4'd0, C_FETCH}};
    op  = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J, OP_J, OP_J};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      u_if.opcode = op[i];
      u_if.mem_ready = rdy[i];
      #1;
      obs = observed();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL branch_jump cycle %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 7) tick();
    end
    exp_retired = exp_retired + 16'd2;
    tests_run++;
    if (u_if.retired_count !== exp_retired) begin
      tests_failed++;
      $display("FAIL branch_jump retire: got %0d want %0d", u_if.retired_count, exp_retired);
    end
  endtask

  task automatic test_illegal();
    logic [20:0] exp [4];
    logic [20:0] obs;
    exp = '{{4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd12, C_TRAP}, {4'd0, C_FETCH}};
    u_if.opcode = OP_BAD;
    u_if.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      obs = observed();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL illegal cycle %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 3) tick();
    end
    tests_run++;
    if (u_if.retired_count !== exp_retired) begin
      tests_failed++;
      $display("FAIL illegal no_retire: got %0d want %0d", u_if.retired_count, exp_retired);
    end
  endtask

  // addi followed by a sw whose write stalls two cycles.
  task automatic test_back_to_back();
    logic [20:0] exp [11];
    logic [5:0]  op  [11];
    logic        rdy [11];
    logic [20:0] obs;
    exp = '{{4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd10, C_AEXEC}, {4'd11, C_AWB},
            {4'd0, C_FETCH}, {4'd1, C_DECODE}, {4'd2, C_MADDR},
            {4'd5, C_MWRITE}, {4'd5, C_MWRITE}, {4'd5, C_MWRITE}, {4'd0, C_FETCH}};
    op  = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      u_if.opcode = op[i];
      u_if.mem_ready = rdy[i];
      #1;
      obs = observed();
      tests_run++;
      if (obs !== exp[i]) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", i, obs, exp[i]);
      end
      if (i < 10) tick();
    end
    exp_retired = exp_retired + 16'd2;
    tests_run++;
    if (u_if.retired_count !== exp_retired) begin
      tests_failed++;
      $display("FAIL back_to_back retire: got %0d want %0d", u_if.retired_count, exp_retired);
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [20:0] obs;
    u_if.opcode = OP_SW;
    u_if.mem_ready = 1'b1;
    tick();                 // FETCH -> DECODE
    tick();                 // DECODE -> MEM_ADDR
    u_if.mem_ready = 1'b0;
    tick();                 // MEM_ADDR -> MEM_WRITE, now stalled
    #1;
    obs = observed();
    tests_run++;
    if (obs !== {4'd5, C_MWRITE}) begin
      tests_failed++;
      $display("FAIL reset_mid_sw pre: got %h want %h", obs, {4'd5, C_MWRITE});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (u_if.state !== 4'd0 || u_if.mem_write !== 1'b0 || u_if.retired_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_sw post: state=%0d mem_write=%b count=%0d, want 0 0 0",
               u_if.state, u_if.mem_write, u_if.retired_count);
    end
    exp_retired = '0;
  endtask

  task automatic test_counter_wrap();
    u_if4.opcode = OP_J;
    u_if4.mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15 * 3; i++) tick();
    tests_run++;
    if (u_if4.retired_count !== 4'd15) begin
      tests_failed++;
      $display("FAIL wrap at_15: got %0d want 15", u_if4.retired_count);
    end
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (u_if4.retired_count !== 4'd0 || u_if4.state !== 4'd0) begin
      tests_failed++;
      $display("FAIL wrap at_16: count=%0d state=%0d want 0 0",
               u_if4.retired_count, u_if4.state);
    end
  endtask

  task automatic test_alu_op_never_11();
    tests_run++;
    if (saw_alu_op_11 !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_op_11: seen=%b want 0", saw_alu_op_11);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid_sw();
    test_counter_wrap();
    test_alu_op_never_11();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
